// File: rtl/car_sequencer_pkg.sv
// Shared microprogram constants for the MSP430 sequencer and control unit:
// CAR encodings, register indices, SR bit positions and operand-class helpers.
package car_sequencer_pkg;

  localparam int unsigned CAR_W = 6;

  // Control address encodings
  localparam logic [CAR_W-1:0] CAR_0        = 6'd0;
  localparam logic [CAR_W-1:0] CAR_REG_REG  = 6'd1;
  localparam logic [CAR_W-1:0] CAR_REG_IDX0 = 6'd2,  CAR_REG_IDX1 = 6'd3;
  localparam logic [CAR_W-1:0] CAR_REG_IDX2 = 6'd4,  CAR_REG_IDX3 = 6'd5;
  localparam logic [CAR_W-1:0] CAR_IND_REG0 = 6'd6,  CAR_IND_REG1 = 6'd7;
  localparam logic [CAR_W-1:0] CAR_IND_IDX0 = 6'd8,  CAR_IND_IDX1 = 6'd9;
  localparam logic [CAR_W-1:0] CAR_IND_IDX2 = 6'd10, CAR_IND_IDX3 = 6'd11;
  localparam logic [CAR_W-1:0] CAR_IND_IDX4 = 6'd12;
  localparam logic [CAR_W-1:0] CAR_IDX_REG0 = 6'd13, CAR_IDX_REG1 = 6'd14;
  localparam logic [CAR_W-1:0] CAR_IDX_REG2 = 6'd15;
  localparam logic [CAR_W-1:0] CAR_IDX_IDX0 = 6'd16, CAR_IDX_IDX1 = 6'd17;
  localparam logic [CAR_W-1:0] CAR_IDX_IDX2 = 6'd18, CAR_IDX_IDX3 = 6'd19;
  localparam logic [CAR_W-1:0] CAR_IDX_IDX4 = 6'd20, CAR_IDX_IDX5 = 6'd21;
  localparam logic [CAR_W-1:0] CAR_OP1_REG  = 6'd22;
  localparam logic [CAR_W-1:0] CAR_OP1_IND0 = 6'd23, CAR_OP1_IND1 = 6'd24;
  localparam logic [CAR_W-1:0] CAR_OP1_IND2 = 6'd25;
  localparam logic [CAR_W-1:0] CAR_OP1_IDX0 = 6'd26, CAR_OP1_IDX1 = 6'd27;
  localparam logic [CAR_W-1:0] CAR_OP1_IDX2 = 6'd28, CAR_OP1_IDX3 = 6'd29;
  localparam logic [CAR_W-1:0] CAR_PUSH_REG0 = 6'd30, CAR_PUSH_REG1 = 6'd31;
  localparam logic [CAR_W-1:0] CAR_PUSH_REG2 = 6'd32;
  localparam logic [CAR_W-1:0] CAR_PUSH_IND0 = 6'd33, CAR_PUSH_IND1 = 6'd34;
  localparam logic [CAR_W-1:0] CAR_PUSH_IND2 = 6'd35;
  localparam logic [CAR_W-1:0] CAR_PUSH_IDX0 = 6'd36, CAR_PUSH_IDX1 = 6'd37;
  localparam logic [CAR_W-1:0] CAR_PUSH_IDX2 = 6'd38, CAR_PUSH_IDX3 = 6'd39;
  localparam logic [CAR_W-1:0] CAR_CALL_REG0 = 6'd40, CAR_CALL_REG1 = 6'd41;
  localparam logic [CAR_W-1:0] CAR_CALL_REG2 = 6'd42;
  localparam logic [CAR_W-1:0] CAR_CALL_IND0 = 6'd43, CAR_CALL_IND1 = 6'd44;
  localparam logic [CAR_W-1:0] CAR_CALL_IND2 = 6'd45;
  localparam logic [CAR_W-1:0] CAR_CALL_IDX0 = 6'd46, CAR_CALL_IDX1 = 6'd47;
  localparam logic [CAR_W-1:0] CAR_CALL_IDX2 = 6'd48, CAR_CALL_IDX3 = 6'd49;
  localparam logic [CAR_W-1:0] CAR_RETI0 = 6'd50, CAR_RETI1 = 6'd51;
  localparam logic [CAR_W-1:0] CAR_RETI2 = 6'd52, CAR_RETI3 = 6'd53;
  localparam logic [CAR_W-1:0] CAR_INT0 = 6'd54, CAR_INT1 = 6'd55, CAR_INT2 = 6'd56;
  localparam logic [CAR_W-1:0] CAR_INT3 = 6'd57, CAR_INT4 = 6'd58;
  localparam logic [CAR_W-1:0] CAR_JMP0 = 6'd59;
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_JMP0;

  // Register indices
  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  // Status register bit positions
  localparam int unsigned SR_C      = 0;
  localparam int unsigned SR_Z      = 1;
  localparam int unsigned SR_N      = 2;
  localparam int unsigned SR_CPUOFF = 4;
  localparam int unsigned SR_V      = 8;

  typedef enum logic [1:0] {CLS_REG, CLS_IDX, CLS_IND} opclass_t;

  // Constant-generator encodings (R3 any mode, R2 indirect modes) act as register operands
  function automatic opclass_t operand_class(input logic [3:0] rsel, input logic [1:0] as);
    if (rsel == REG_CG || (rsel == REG_SR && as[1])) return CLS_REG;
    case (as)
      2'b00:   return CLS_REG;
      2'b01:   return CLS_IDX;
      default: return CLS_IND;
    endcase
  endfunction

  function automatic logic [CAR_W-1:0] class_select(input opclass_t cls,
                                                    input logic [CAR_W-1:0] r,
                                                    input logic [CAR_W-1:0] x,
                                                    input logic [CAR_W-1:0] i);
    case (cls)
      CLS_IDX: return x;
      CLS_IND: return i;
      default: return r;
    endcase
  endfunction

  function automatic logic is_terminal(input logic [CAR_W-1:0] car);
    case (car)
      CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4, CAR_IDX_REG2,
      CAR_IDX_IDX5, CAR_OP1_REG, CAR_OP1_IND2, CAR_OP1_IDX3, CAR_PUSH_REG2,
      CAR_PUSH_IND2, CAR_PUSH_IDX3, CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3,
      CAR_RETI3, CAR_INT4, CAR_JMP0: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/car_sequencer_jmp_cond.sv
// Jump condition evaluator: decides whether a conditional jump is taken
// from the 3-bit condition field and the {V,N,Z,C} flags.
module jmp_cond (
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic v, n, z, c;
  assign {v, n, z, c} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0: taken = ~z;
      3'd1: taken = z;
      3'd2: taken = ~c;
      3'd3: taken = c;
      3'd4: taken = n;
      3'd5: taken = ~(n ^ v);
      3'd6: taken = n ^ v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/car_sequencer.sv
// MSP430 microprogram sequencer: decodes IR in CAR_0, dispatches to the first
// state of the matching microsequence, steps through it and returns to CAR_0.
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int unsigned CAR_BITS = CAR_W
) (
  input  logic                MCLK,
  input  logic                RST_n,
  input  logic [15:0]         IR,
  input  logic [15:0]         SR,
  input  logic                INT_req,
  input  logic                HOLD,
  output logic [CAR_BITS-1:0] CAR,
  output logic                FETCH,
  output logic                ILLEGAL
);

  logic [CAR_BITS-1:0] car_q, car_d;
  logic                illegal_q, illegal_d;
  logic [CAR_W-1:0]    disp_car;
  logic                disp_illegal;
  logic                jmp_taken;
  logic                is_jump, is_fmt2, is_fmt1;
  logic [2:0]          f2_op;
  opclass_t            f1_cls, f2_cls;

  // Byte/word select and the remaining SR bits do not affect sequencing
  logic unused_bits;
  assign unused_bits = ^{IR[6], SR[15:9], SR[7:5], SR[3]};

  jmp_cond u_jmp_cond (
    .cond  (IR[12:10]),
    .flags ({SR[SR_V], SR[SR_N], SR[SR_Z], SR[SR_C]}),
    .taken (jmp_taken)
  );

  assign is_jump = (IR[15:13] == 3'b001);
  assign is_fmt2 = (IR[15:10] == 6'b000100);
  assign is_fmt1 = (IR[15:14] != 2'b00);
  assign f2_op   = IR[9:7];
  assign f1_cls  = operand_class(IR[11:8], IR[5:4]);
  assign f2_cls  = operand_class(IR[3:0], IR[5:4]);

  // Instruction dispatch target; a not-taken jump or an illegal word returns to CAR_0
  always_comb begin
    disp_car     = CAR_0;
    disp_illegal = 1'b0;
    if (is_jump) begin
      if (jmp_taken) disp_car = CAR_JMP0;
    end else if (is_fmt2) begin
      case (f2_op)
        3'd4:    disp_car = class_select(f2_cls, CAR_PUSH_REG0, CAR_PUSH_IDX0, CAR_PUSH_IND0);
        3'd5:    disp_car = class_select(f2_cls, CAR_CALL_REG0, CAR_CALL_IDX0, CAR_CALL_IND0);
        3'd6:    disp_car = CAR_RETI0;
        3'd7:    disp_illegal = 1'b1;
        default: disp_car = class_select(f2_cls, CAR_OP1_REG, CAR_OP1_IDX0, CAR_OP1_IND0);
      endcase
    end else if (is_fmt1) begin
      if (IR[7]) disp_car = class_select(f1_cls, CAR_REG_IDX0, CAR_IDX_IDX0, CAR_IND_IDX0);
      else       disp_car = class_select(f1_cls, CAR_REG_REG, CAR_IDX_REG0, CAR_IND_REG0);
    end else begin
      disp_illegal = 1'b1;
    end
  end

  // Next control address; HOLD freezes everything, interrupts only enter from CAR_0
  always_comb begin
    car_d     = car_q;
    illegal_d = 1'b0;
    FETCH     = 1'b0;
    if (HOLD) begin
      illegal_d = illegal_q;
    end else if (car_q == CAR_BITS'(CAR_0)) begin
      if (INT_req) begin
        car_d = CAR_BITS'(CAR_INT0);
      end else if (!SR[SR_CPUOFF]) begin
        FETCH     = 1'b1;
        car_d     = CAR_BITS'(disp_car);
        illegal_d = disp_illegal;
      end
    end else if (car_q > CAR_BITS'(CAR_LAST) || is_terminal(CAR_W'(car_q))) begin
      car_d = CAR_BITS'(CAR_0);
    end else begin
      car_d = car_q + CAR_BITS'(1);
    end
  end

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      car_q     <= CAR_BITS'(CAR_0);
      illegal_q <= 1'b0;
    end else begin
      car_q     <= car_d;
      illegal_q <= illegal_d;
    end
  end

  assign CAR     = car_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: directed scenarios followed by randomized
// instruction streams checked against a sequence-level reference model.
module tb_car_sequencer;

  logic        MCLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic [15:0] SR = 16'h0000;
  logic        INT_req = 1'b0;
  logic        HOLD = 1'b0;
  logic [5:0]  CAR;
  logic        FETCH;
  logic        ILLEGAL;

  int total = 0;
  int bad   = 0;

  car_sequencer dut (
    .MCLK    (MCLK),
    .RST_n   (RST_n),
    .IR      (IR),
    .SR      (SR),
    .INT_req (INT_req),
    .HOLD    (HOLD),
    .CAR     (CAR),
    .FETCH   (FETCH),
    .ILLEGAL (ILLEGAL)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // From CAR_0: expect CAR to walk start..start+len-1 and then return to 0
  task automatic chk_run(input string tag, input int start, input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      INT_req = 1'b0;
      chk({tag, "_car"}, 32'(CAR), 32'(start + i));
      chk({tag, "_fetch_busy"}, 32'(FETCH), 32'd0);
    end
    tick();
    chk({tag, "_return"}, 32'(CAR), 32'd0);
  endtask

  // Operand class: 0 = register, 1 = indexed, 2 = indirect
  function automatic int opclass(input logic [3:0] r, input logic [1:0] as);
    if (r == 4'd3) return 0;
    if (r == 4'd2 && as >= 2'd2) return 0;
    if (as == 2'd0) return 0;
    if (as == 2'd1) return 1;
    return 2;
  endfunction

  // Reference: starting address and length of the sequence dispatched from CAR_0
  function automatic void model(input logic [15:0] ir, input logic [15:0] sr, input logic intr,
                                output int start, output int len, output bit ill);
    int op1_s[3]  = '{22, 26, 23};
    int op1_l[3]  = '{1, 4, 3};
    int push_s[3] = '{30, 36, 33};
    int push_l[3] = '{3, 4, 3};
    int call_s[3] = '{40, 46, 43};
    int call_l[3] = '{3, 4, 3};
    int d0_s[3]   = '{1, 13, 6};
    int d0_l[3]   = '{1, 3, 2};
    int d1_s[3]   = '{2, 16, 8};
    int d1_l[3]   = '{4, 6, 5};
    bit c, z, n, v, take;
    int k;
    start = 0; len = 0; ill = 1'b0;
    c = sr[0]; z = sr[1]; n = sr[2]; v = sr[8];
    if (intr) begin start = 54; len = 5; return; end
    if (sr[4]) return;
    if (ir[15:13] == 3'b001) begin
      case (ir[12:10])
        3'd0: take = !z;
        3'd1: take = z;
        3'd2: take = !c;
        3'd3: take = c;
        3'd4: take = n;
        3'd5: take = (n == v);
        3'd6: take = (n != v);
        default: take = 1'b1;
      endcase
      if (take) begin start = 59; len = 1; end
    end else if (ir[15:10] == 6'b000100) begin
      k = opclass(ir[3:0], ir[5:4]);
      if (ir[9:7] == 3'd7)      ill = 1'b1;
      else if (ir[9:7] == 3'd6) begin start = 50; len = 4; end
      else if (ir[9:7] == 3'd5) begin start = call_s[k]; len = call_l[k]; end
      else if (ir[9:7] == 3'd4) begin start = push_s[k]; len = push_l[k]; end
      else                      begin start = op1_s[k]; len = op1_l[k]; end
    end else if (ir[15:14] != 2'b00) begin
      k = opclass(ir[11:8], ir[5:4]);
      if (ir[7]) begin start = d1_s[k]; len = d1_l[k]; end
      else       begin start = d0_s[k]; len = d0_l[k]; end
    end else begin
      ill = 1'b1;
    end
  endfunction

  initial begin
    int cur, m_start, m_len, q[$];
    bit ill_exp, m_ill, fetch_exp;
    logic [31:0] r;

    // Reset and REG_REG
    #1;
    chk("rst_car", 32'(CAR), 32'd0);
    chk("rst_ill", 32'(ILLEGAL), 32'd0);
    IR = 16'h4405;
    #11 RST_n = 1'b1;
    chk("regreg_fetch", 32'(FETCH), 32'd1);
    chk_run("regreg", 1, 1);

    // Format 1 indexed -> indexed
    IR = 16'h4592;
    chk_run("idxidx", 16, 6);

    // Jumps
    IR = 16'h2400; SR = 16'h0002;
    chk_run("jeq_taken", 59, 1);
    SR = 16'h0000;
    #1 chk("jeq_nt_fetch", 32'(FETCH), 32'd1);
    tick();
    chk("jeq_nt_car", 32'(CAR), 32'd0);
    IR = 16'h3400; SR = 16'h0104;
    chk_run("jge", 59, 1);
    SR = 16'h0000;

    // Constant generator push and CALL #imm
    IR = 16'h1223;
    chk_run("push_cg", 30, 3);
    IR = 16'h12B0;
    chk_run("call_imm", 43, 3);

    // Interrupt raised mid-sequence waits for CAR_0
    IR = 16'h45A2;
    tick(); chk("indidx0", 32'(CAR), 32'd8);
    tick(); chk("indidx1", 32'(CAR), 32'd9);
    INT_req = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      tick(); chk("indidx_int_pending", 32'(CAR), 32'(i));
    end
    tick(); chk("indidx_done", 32'(CAR), 32'd0);
    #1 chk("int_fetch", 32'(FETCH), 32'd0);
    chk_run("int", 54, 5);

    // Interrupt while CPUOFF, then CPUOFF idle
    SR = 16'h0010; INT_req = 1'b1;
    #1 chk("int_cpuoff_fetch", 32'(FETCH), 32'd0);
    chk_run("int_cpuoff", 54, 5);
    IR = 16'h4405;
    #1 chk("cpuoff_fetch", 32'(FETCH), 32'd0);
    tick(); chk("cpuoff_car", 32'(CAR), 32'd0);
    SR = 16'h0000;

    // Illegal word
    IR = 16'h0000;
    #1 chk("illegal_fetch", 32'(FETCH), 32'd1);
    tick();
    chk("illegal_car", 32'(CAR), 32'd0);
    chk("illegal_pulse", 32'(ILLEGAL), 32'd1);
    SR = 16'h0010;
    tick();
    chk("illegal_clear", 32'(ILLEGAL), 32'd0);
    SR = 16'h0000;

    // HOLD in CAR_0 and mid-sequence
    IR = 16'h4405; HOLD = 1'b1;
    #1 chk("hold0_fetch", 32'(FETCH), 32'd0);
    tick(); chk("hold0_car", 32'(CAR), 32'd0);
    HOLD = 1'b0;
    IR = 16'h4482;
    tick(); chk("regidx0", 32'(CAR), 32'd2);
    tick(); chk("regidx1", 32'(CAR), 32'd3);
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_frozen", 32'(CAR), 32'd3);
    end
    HOLD = 1'b0;
    tick(); chk("regidx2", 32'(CAR), 32'd4);
    tick(); chk("regidx3", 32'(CAR), 32'd5);
    tick(); chk("regidx_done", 32'(CAR), 32'd0);

    // Asynchronous reset mid-sequence
    IR = 16'h4592;
    for (int i = 16; i <= 19; i++) begin
      tick(); chk("idxidx_pre_rst", 32'(CAR), 32'(i));
    end
    #2 RST_n = 1'b0;
    #1 chk("async_rst_car", 32'(CAR), 32'd0);
    chk("async_rst_ill", 32'(ILLEGAL), 32'd0);
    IR = 16'h4405;
    #1 RST_n = 1'b1;
    chk_run("post_rst", 1, 1);

    // Randomized streams against the reference model
    cur = 0; ill_exp = 1'b0;
    for (int step = 0; step < 4000; step++) begin
      chk("rnd_car", 32'(CAR), 32'(cur));
      chk("rnd_ill", 32'(ILLEGAL), 32'(ill_exp));
      r = $urandom;
      case ($urandom_range(0, 4))
        0: IR = r[15:0];
        1: IR = {3'b001, r[12:0]};
        2: begin
          IR = {6'b000100, r[9:0]};
          if (r[20]) IR[3:0] = 4'(r[21] ? 3 : 2);
        end
        3: begin
          IR = r[15:0];
          if (IR[15:14] == 2'b00) IR[15:14] = 2'b01;
          if (r[20]) IR[11:8] = 4'(r[21] ? 3 : 2);
        end
        default: IR = {4'(r[16] ? 1 : 0), r[11:0]};
      endcase
      r = $urandom;
      SR = r[15:0];
      SR[4] = ($urandom_range(0, 7) == 0);
      INT_req = ($urandom_range(0, 9) == 0);
      HOLD = ($urandom_range(0, 7) == 0);
      fetch_exp = (cur == 0) && !HOLD && !INT_req && !SR[4];
      #1 chk("rnd_fetch", 32'(FETCH), 32'(fetch_exp));
      if (!HOLD) begin
        if (cur == 0) begin
          model(IR, SR, INT_req, m_start, m_len, m_ill);
          ill_exp = m_ill;
          if (m_len > 0) begin
            cur = m_start;
            for (int k = 1; k < m_len; k++) q.push_back(m_start + k);
            q.push_back(0);
          end
        end else begin
          cur = q.pop_front();
          ill_exp = 1'b0;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
